// File: rtl/hsv_core_flush_ctrl.sv
// hsv_core_flush_ctrl: flush/trap sequencer for the hsv_core commit stage.
// Runs a four-state flush handshake (RUN, CAPTURE, REQ, RELEASE) with every
// flushable stage on jumps, traps and interrupts. It also produces the flush
// target PC and a one-cycle trap-entry pulse for the CSR unit.
// Optional build macro: HSV_FLUSH_WATCHDOG_EN adds a sticky flush_timeout
// flag, driven by a saturating counter over REQ+RELEASE cycles.
module hsv_core_flush_ctrl #(
  parameter int          NUM_STAGES = 5,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
`ifdef HSV_FLUSH_WATCHDOG_EN
  ,
  parameter int          TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                  clk_core,
  input  logic                  rst_core_n,
  input  logic                  ctrl_commit,
  input  logic                  ctrl_flush_begin,
  input  logic                  ctrl_trap,
  input  logic [4:0]            ctrl_trap_cause,
  input  logic [31:0]           ctrl_trap_value,
  input  logic [31:0]           ctrl_next_pc,
  input  logic                  irq_pending,
  input  logic [4:0]            irq_cause,
  input  logic [31:0]           trap_vector,
  output logic                  ctrl_begin_irq,
  output logic                  flush_req,
  input  logic [NUM_STAGES-1:0] flush_ack,
  output logic [31:0]           flush_target,
  output logic                  halt,
  output logic                  trap_take,
  output logic                  trap_interrupt,
  output logic [4:0]            trap_cause,
  output logic [31:0]           trap_value,
  output logic [31:0]           trap_epc
`ifdef HSV_FLUSH_WATCHDOG_EN
  ,
  output logic                  flush_timeout
`endif
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_REQ     = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t state;
  logic   is_irq;

  // An interrupt is accepted only in RUN, only when no flush is starting, and
  // never in a cycle where an instruction retires, so no writeback is lost.
  assign ctrl_begin_irq = (state == ST_RUN) && !ctrl_flush_begin &&
                          irq_pending && !ctrl_commit;

  // Flush sequencer with registered handshake and trap outputs.
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state          <= ST_REQ;
      is_irq         <= 1'b0;
      flush_req      <= 1'b1;
      halt           <= 1'b1;
      flush_target   <= RESET_PC;
      trap_take      <= 1'b0;
      trap_interrupt <= 1'b0;
      trap_cause     <= 5'd0;
      trap_value     <= 32'd0;
      trap_epc       <= 32'd0;
    end else begin
      trap_take <= 1'b0;
      case (state)
        ST_RUN: begin
          if (ctrl_flush_begin) begin
            state  <= ST_CAPTURE;
            is_irq <= 1'b0;
            halt   <= 1'b1;
          end else if (ctrl_begin_irq) begin
            state  <= ST_CAPTURE;
            is_irq <= 1'b1;
            halt   <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          // Commit's registered trap flag/cause/value are valid only now.
          state     <= ST_REQ;
          flush_req <= 1'b1;
          if (is_irq) begin
            trap_take      <= 1'b1;
            trap_interrupt <= 1'b1;
            trap_cause     <= irq_cause;
            trap_value     <= 32'd0;
            trap_epc       <= ctrl_next_pc;
            flush_target   <= trap_vector;
          end else if (ctrl_trap) begin
            trap_take      <= 1'b1;
            trap_interrupt <= 1'b0;
            trap_cause     <= ctrl_trap_cause;
            trap_value     <= ctrl_trap_value;
            trap_epc       <= ctrl_next_pc;
            flush_target   <= trap_vector;
          end else begin
            flush_target   <= ctrl_next_pc;
          end
        end
        ST_REQ: begin
          if (&flush_ack) begin
            flush_req <= 1'b0;
            state     <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          // flush_target holds here; stages load it while ack=1, req=0.
          if (!(|flush_ack)) begin
            state <= ST_RUN;
            halt  <= 1'b0;
          end
        end
        default: begin
          state     <= ST_REQ;
          flush_req <= 1'b1;
          halt      <= 1'b1;
        end
      endcase
    end
  end

`ifdef HSV_FLUSH_WATCHDOG_EN
  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] wd_cnt;
  logic       wd_sticky;
  logic       wd_busy;
  logic       wd_hit;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // wd_cnt equals the number of the current REQ/RELEASE cycle, so the
  // flag is raised in the cycle that reaches the limit.
  assign wd_busy       = (state == ST_REQ) || (state == ST_RELEASE);
  assign wd_hit        = wd_busy && (wd_cnt >= WD_LIMIT);
  assign flush_timeout = wd_sticky | wd_hit;

  // Saturating flush-duration counter with a sticky timeout flag.
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      wd_cnt    <= 8'd0;
      wd_sticky <= 1'b0;
    end else begin
      if ((state == ST_RUN) && (ctrl_flush_begin || ctrl_begin_irq)) begin
        wd_cnt <= 8'd0;
      end else if (state == ST_CAPTURE) begin
        wd_cnt <= 8'd1;
      end else if (wd_busy) begin
        wd_cnt <= sat_inc8(wd_cnt);
      end
      if (wd_hit) begin
        wd_sticky <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hsv_core_flush_ctrl.sv
// Scoreboard bench for hsv_core_flush_ctrl: each flush pushes its expected
// target/trap result, which is compared when halt releases.
module tb_hsv_core_flush_ctrl;
  localparam int          NS  = 5;
  localparam logic [31:0] RPC = 32'h0000_2000;

  logic          clk_core;
  logic          rst_core_n;
  logic          ctrl_commit;
  logic          ctrl_flush_begin;
  logic          ctrl_trap;
  logic [4:0]    ctrl_trap_cause;
  logic [31:0]   ctrl_trap_value;
  logic [31:0]   ctrl_next_pc;
  logic          irq_pending;
  logic [4:0]    irq_cause;
  logic [31:0]   trap_vector;
  logic          ctrl_begin_irq;
  logic          flush_req;
  logic [NS-1:0] flush_ack;
  logic [31:0]   flush_target;
  logic          halt;
  logic          trap_take;
  logic          trap_interrupt;
  logic [4:0]    trap_cause;
  logic [31:0]   trap_value;
  logic [31:0]   trap_epc;
`ifdef HSV_FLUSH_WATCHDOG_EN
  logic          flush_timeout;
`endif

  hsv_core_flush_ctrl #(
    .NUM_STAGES(NS),
    .RESET_PC(RPC)
`ifdef HSV_FLUSH_WATCHDOG_EN
    ,
    .TIMEOUT_CYCLES(10)
`endif
  ) dut (
    .clk_core(clk_core),
    .rst_core_n(rst_core_n),
    .ctrl_commit(ctrl_commit),
    .ctrl_flush_begin(ctrl_flush_begin),
    .ctrl_trap(ctrl_trap),
    .ctrl_trap_cause(ctrl_trap_cause),
    .ctrl_trap_value(ctrl_trap_value),
    .ctrl_next_pc(ctrl_next_pc),
    .irq_pending(irq_pending),
    .irq_cause(irq_cause),
    .trap_vector(trap_vector),
    .ctrl_begin_irq(ctrl_begin_irq),
    .flush_req(flush_req),
    .flush_ack(flush_ack),
    .flush_target(flush_target),
    .halt(halt),
    .trap_take(trap_take),
    .trap_interrupt(trap_interrupt),
    .trap_cause(trap_cause),
    .trap_value(trap_value),
    .trap_epc(trap_epc)
`ifdef HSV_FLUSH_WATCHDOG_EN
    ,
    .flush_timeout(flush_timeout)
`endif
  );

  initial clk_core = 1'b0;
  always #5 clk_core = ~clk_core;

  // Stage ack model: each ack is flush_req delayed by 1+dly[i] cycles; 1 in reset.
  int          dly [NS];
  logic [31:0] hist;
  always @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) hist <= '1;
    else             hist <= {hist[30:0], flush_req};
  end
  always_comb begin
    flush_ack = '0;
    for (int i = 0; i < NS; i++) flush_ack[i] = hist[dly[i][4:0]];
  end

  typedef struct {
    bit          take;
    bit          intr;
    logic [4:0]  cause;
    logic [31:0] val;
    logic [31:0] epc;
    logic [31:0] tgt;
    int          req_cycles;
  } item_t;

  item_t sb[$];
  int    n_chk  = 0;
  int    n_fail = 0;

  bit          last_intr;
  logic [4:0]  last_cause;
  logic [31:0] last_val;
  logic [31:0] last_epc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: count trap pulses and flush_req cycles, score each halt release.
  int   take_cnt;
  int   req_cnt;
  logic prev_halt;
  always @(negedge clk_core) begin
    if (!rst_core_n) begin
      take_cnt  = 0;
      req_cnt   = 0;
      prev_halt = 1'b1;
    end else begin
      if (trap_take) take_cnt++;
      if (flush_req) req_cnt++;
      if (prev_halt && !halt) begin
        check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          item_t it;
          it = sb.pop_front();
          check("take_pulses", 64'(take_cnt), it.take ? 64'd1 : 64'd0);
          check("trap_interrupt", 64'(trap_interrupt), 64'(it.intr));
          check("trap_cause", 64'(trap_cause), 64'(it.cause));
          check("trap_value", 64'(trap_value), 64'(it.val));
          check("trap_epc", 64'(trap_epc), 64'(it.epc));
          check("flush_target", 64'(flush_target), 64'(it.tgt));
          if (it.req_cycles >= 0) check("req_cycles", 64'(req_cnt), 64'(it.req_cycles));
        end
        take_cnt = 0;
        req_cnt  = 0;
      end
      prev_halt = halt;
    end
  end

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk_core);
      if (sb.size() == 0 && !halt) begin
        ok = 1'b1;
        break;
      end
    end
    check("flush_done", 64'(ok), 64'd1);
    for (int n = 0; n < 2; n++) begin
      @(negedge clk_core);
      check("stay_run", 64'(halt), 64'd0);
    end
  endtask

  function automatic int max_dly();
    int m = 0;
    for (int i = 0; i < NS; i++) if (dly[i] > m) m = dly[i];
    return m;
  endfunction

  function automatic item_t mk_item(input bit use_irq, input bit trap, input logic [4:0] cause,
                                    input logic [31:0] val, input logic [31:0] npc);
    item_t it;
    it.req_cycles = max_dly() + 2;
    if (use_irq || trap) begin
      it.take = 1'b1;
      it.intr = use_irq;
      it.cause = cause;
      it.val = use_irq ? 32'd0 : val;
      it.epc = npc;
      it.tgt = trap_vector;
      last_intr = it.intr; last_cause = it.cause; last_val = it.val; last_epc = it.epc;
    end else begin
      it.take = 1'b0;
      it.intr = last_intr; it.cause = last_cause; it.val = last_val; it.epc = last_epc;
      it.tgt = npc;
    end
    return it;
  endfunction

  // One flush: jump/exception via ctrl_flush_begin, or an interrupt held off by commits.
  task automatic do_flush(input bit use_irq, input bit trap, input logic [4:0] cause,
                          input logic [31:0] val, input logic [31:0] npc, input bit noise);
    sb.push_back(mk_item(use_irq, trap, cause, val, npc));
    if (use_irq) begin
      @(posedge clk_core); #1;
      ctrl_commit = 1'b1; irq_pending = 1'b1; irq_cause = cause; ctrl_next_pc = npc;
      for (int k = 0; k < 2; k++) begin
        @(negedge clk_core);
        check("irq_held_by_commit", 64'(ctrl_begin_irq), 64'd0);
        @(posedge clk_core); #1;
      end
      ctrl_commit = 1'b0;
      @(negedge clk_core);
      check("irq_accept", 64'(ctrl_begin_irq), 64'd1);
      @(posedge clk_core); #1;
      irq_pending = 1'b0;
      @(posedge clk_core); #1;
      irq_cause = ~cause; ctrl_next_pc = ~npc;
    end else begin
      @(posedge clk_core); #1;
      ctrl_flush_begin = 1'b1;
      @(posedge clk_core); #1;
      ctrl_flush_begin = 1'b0;
      ctrl_trap = trap; ctrl_trap_cause = cause; ctrl_trap_value = val; ctrl_next_pc = npc;
      @(negedge clk_core);
      check("halt_in_capture", 64'(halt), 64'd1);
      @(posedge clk_core); #1;
      ctrl_trap = 1'b0; ctrl_trap_cause = ~cause; ctrl_trap_value = ~val; ctrl_next_pc = ~npc;
    end
    if (noise) begin
      for (int k = 0; k < 3; k++) begin
        ctrl_flush_begin = 1'b1; irq_pending = 1'b1;
        @(posedge clk_core); #1;
      end
      ctrl_flush_begin = 1'b0; irq_pending = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    item_t it;
    bit    got_irq;
    rst_core_n = 1'b0;
    ctrl_commit = 1'b0; ctrl_flush_begin = 1'b0; ctrl_trap = 1'b0;
    ctrl_trap_cause = 5'd0; ctrl_trap_value = 32'd0; ctrl_next_pc = 32'd0;
    irq_pending = 1'b0; irq_cause = 5'd0; trap_vector = 32'h0000_0100;
    for (int i = 0; i < NS; i++) dly[i] = 0;
    last_intr = 1'b0; last_cause = 5'd0; last_val = 32'd0; last_epc = 32'd0;

    #12;
    check("rst_flush_req", 64'(flush_req), 64'd1);
    check("rst_halt", 64'(halt), 64'd1);
    check("rst_target", 64'(flush_target), 64'(RPC));
    check("rst_trap_take", 64'(trap_take), 64'd0);
    check("rst_trap_cause", 64'(trap_cause), 64'd0);
    check("rst_trap_epc", 64'(trap_epc), 64'd0);
    check("rst_begin_irq", 64'(ctrl_begin_irq), 64'd0);
`ifdef HSV_FLUSH_WATCHDOG_EN
    check("rst_timeout", 64'(flush_timeout), 64'd0);
`endif
    it = mk_item(1'b0, 1'b0, 5'd0, 32'd0, RPC);
    it.req_cycles = -1;
    sb.push_back(it);
    @(posedge clk_core); #1;
    rst_core_n = 1'b1;
    wait_idle();

    // Jump, exception, interrupt behind two commits
    do_flush(1'b0, 1'b0, 5'd0, 32'd0, 32'h0000_0400, 1'b0);
    do_flush(1'b0, 1'b1, 5'd2, 32'hDEAD_BEEF, 32'h0000_0080, 1'b0);
    trap_vector = 32'h0000_0180;
    do_flush(1'b1, 1'b0, 5'd7, 32'd0, 32'h0000_0240, 1'b0);

    // Staggered acks with ignored flush/irq requests during the flush
    for (int i = 0; i < NS; i++) dly[i] = i;
    do_flush(1'b0, 1'b1, 5'd4, 32'h0000_1234, 32'h0000_0300, 1'b1);
    for (int i = 0; i < NS; i++) dly[i] = 0;

    // Flush and irq together: the jump first, then the irq retaken in RUN
    sb.push_back(mk_item(1'b0, 1'b0, 5'd0, 32'd0, 32'h0000_0500));
    sb.push_back(mk_item(1'b1, 1'b0, 5'd9, 32'd0, 32'h0000_0500));
    @(posedge clk_core); #1;
    ctrl_flush_begin = 1'b1; irq_pending = 1'b1; irq_cause = 5'd9; ctrl_commit = 1'b0;
    @(negedge clk_core);
    check("flush_beats_irq", 64'(ctrl_begin_irq), 64'd0);
    @(posedge clk_core); #1;
    ctrl_flush_begin = 1'b0; ctrl_trap = 1'b0; ctrl_next_pc = 32'h0000_0500;
    got_irq = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk_core);
      if (ctrl_begin_irq) begin
        got_irq = 1'b1;
        break;
      end
    end
    check("irq_retaken", 64'(got_irq), 64'd1);
    @(posedge clk_core); #1;
    irq_pending = 1'b0;
    wait_idle();

    // A jump leaves the interrupt's trap fields untouched
    do_flush(1'b0, 1'b0, 5'd0, 32'd0, 32'h0000_0600, 1'b0);

`ifdef HSV_FLUSH_WATCHDOG_EN
    dly[0] = 20;
    sb.push_back(mk_item(1'b0, 1'b0, 5'd0, 32'd0, 32'h0000_0700));
    @(posedge clk_core); #1;
    ctrl_flush_begin = 1'b1;
    @(posedge clk_core); #1;
    ctrl_flush_begin = 1'b0; ctrl_next_pc = 32'h0000_0700;
    @(posedge clk_core); #1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk_core);
      if (k == 9)  check("timeout_before", 64'(flush_timeout), 64'd0);
      if (k == 10) check("timeout_hit", 64'(flush_timeout), 64'd1);
      @(posedge clk_core); #1;
    end
    wait_idle();
    check("timeout_sticky", 64'(flush_timeout), 64'd1);
    dly[0] = 0;
`endif

    // Asynchronous reset in the middle of an exception flush
    @(posedge clk_core); #1;
    ctrl_flush_begin = 1'b1;
    @(posedge clk_core); #1;
    ctrl_flush_begin = 1'b0; ctrl_trap = 1'b1; ctrl_trap_cause = 5'd3;
    ctrl_trap_value = 32'h0BAD_F00D; ctrl_next_pc = 32'h0000_0900;
    @(posedge clk_core); #1;
    ctrl_trap = 1'b0;
    check("take_before_reset", 64'(trap_take), 64'd1);
    #2 rst_core_n = 1'b0;
    #1;
    check("arst_trap_take", 64'(trap_take), 64'd0);
    check("arst_flush_req", 64'(flush_req), 64'd1);
    check("arst_halt", 64'(halt), 64'd1);
    check("arst_target", 64'(flush_target), 64'(RPC));
    check("arst_trap_value", 64'(trap_value), 64'd0);
    check("arst_trap_epc", 64'(trap_epc), 64'd0);
`ifdef HSV_FLUSH_WATCHDOG_EN
    check("arst_timeout", 64'(flush_timeout), 64'd0);
`endif
    sb.delete();
    last_intr = 1'b0; last_cause = 5'd0; last_val = 32'd0; last_epc = 32'd0;
    it = mk_item(1'b0, 1'b0, 5'd0, 32'd0, RPC);
    it.req_cycles = -1;
    sb.push_back(it);
    @(posedge clk_core); #1;
    rst_core_n = 1'b1;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
